// File: rtl/mem_word_bridge_pkg.sv
// Shared types and constants for the memory word bridge.
// States, default memory width and byte-lane helpers.
package mem_word_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        WR0  = 3'd4,
        WR1  = 3'd5,
        RESP = 3'd6
    } state_t;

    localparam int MEM_AW_DEFAULT = 14;

    localparam int LO_LANE = 0;
    localparam int HI_LANE = 1;

    // Select one byte lane of a 16-bit host word.
    function automatic logic [7:0] lane_byte(
        input logic [15:0] w,
        input int          lane
    );
        return w[lane*8 +: 8];
    endfunction

endpackage

// File: rtl/mem_word_bridge.sv
// Word-to-byte bridge between the sequencer and byte-wide main memory.
// Build option: define MEM_WORD_BRIDGE_ALIGN_CHECK_EN to reject odd addresses.
module mem_word_bridge
    import mem_word_bridge_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int MEM_AW = MEM_AW_DEFAULT,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata
);

    localparam logic [MEM_AW-1:0] ADDR_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic [MEM_AW-1:0]   r_addr;
    logic [7:0]          r_hi_wbyte;
    logic [7:0]          r_lo_rbyte;

    logic                r_req_ready;
    logic                r_resp_valid;
    logic [DATA_W-1:0]   r_resp_rdata;
    logic                r_resp_err;
    logic [MEM_AW-1:0]   r_mem_addr;
    logic [7:0]          r_mem_wdata;
    logic                r_mem_we;

    logic                w_accept;
    logic                w_oor;
    logic                w_misalign;
    logic                w_reject;
    logic [MEM_AW-1:0]   w_next_addr;

    assign w_accept    = req_valid && r_req_ready;
    assign w_oor       = (req_addr >> MEM_AW) != '0;
`ifdef MEM_WORD_BRIDGE_ALIGN_CHECK_EN
    assign w_misalign  = req_addr[0];
`else
    assign w_misalign  = 1'b0;
`endif
    assign w_reject    = w_oor || w_misalign;
    // High byte lives at A+1 and wraps to 0 past the top of memory.
    assign w_next_addr = r_addr + ADDR_ONE;

    // Request sequencer: splits one word access into two byte accesses.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_hi_wbyte   <= '0;
            r_lo_rbyte   <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_addr      <= req_addr[MEM_AW-1:0];
                        r_hi_wbyte  <= lane_byte(req_wdata, HI_LANE);
                        if (w_reject) begin
                            // Rejected requests never touch memory.
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else if (req_write) begin
                            r_state     <= WR0;
                            r_mem_addr  <= req_addr[MEM_AW-1:0];
                            r_mem_wdata <= lane_byte(req_wdata, LO_LANE);
                            r_mem_we    <= 1'b1;
                        end else begin
                            r_state    <= RD0;
                            r_mem_addr <= req_addr[MEM_AW-1:0];
                        end
                    end
                end
                RD0: begin
                    r_state    <= RD1;
                    r_mem_addr <= w_next_addr;
                end
                RD1: begin
                    // Memory returns the low byte one cycle after RD0.
                    r_state    <= RD2;
                    r_lo_rbyte <= mem_rdata;
                end
                RD2: begin
                    r_state      <= RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= {mem_rdata, r_lo_rbyte};
                end
                WR0: begin
                    r_state     <= WR1;
                    r_mem_addr  <= w_next_addr;
                    r_mem_wdata <= r_hi_wbyte;
                end
                WR1: begin
                    // Read data is left untouched on write completion.
                    r_state      <= RESP;
                    r_mem_we     <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_mem_we    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_we     = r_mem_we;

endmodule

// File: tb/tb_mem_word_bridge.sv
// Self-checking bench for mem_word_bridge with a byte memory model.
// Word-level reference memory predicts every response.
module tb_mem_word_bridge;

    localparam int DEPTH = 16384;

`ifdef MEM_WORD_BRIDGE_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic [13:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [DEPTH];
    logic [7:0]  ref_mem [DEPTH];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] last_rd = '0;

    logic [13:0] wq_addr [$];
    logic [7:0]  wq_data [$];
    int          wq_cyc  [$];

    mem_word_bridge dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Byte memory with a registered read port; logs every write.
    always @(posedge clock) begin
        mem_rdata <= mem[mem_addr];
        if (mem_we === 1'b1) begin
            mem[mem_addr] = mem_wdata;
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
            wq_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_wq();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
    endtask

    // One complete word transaction, checked against the reference memory.
    task automatic xfer(input bit wr, input logic [15:0] a,
                        input logic [15:0] wd, input string tag);
        bit          exp_err;
        int          n;
        int          ai;
        int          exp_lat;
        int          exp_wr;
        logic [13:0] ma0;
        logic [15:0] exp_rd;
        ai      = int'(a[13:0]);
        exp_err = (a[15:14] != 2'b00) || (ALIGN && a[0]);
        clear_wq();
        @(negedge clock);
        chk({tag, ".ready_idle"}, req_ready, 1);
        ma0       = mem_addr;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        @(negedge clock);
        req_valid = 1'b0;
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        n = 1;
        chk({tag, ".ready_busy"}, req_ready, 0);
        while (resp_valid !== 1'b1 && n < 12) begin
            @(negedge clock);
            n++;
        end
        if (exp_err) begin
            exp_rd  = '0;
            exp_lat = 1;
            exp_wr  = 0;
        end else if (wr) begin
            exp_rd  = last_rd;
            exp_lat = 3;
            exp_wr  = 2;
            ref_mem[ai]             = wd[7:0];
            ref_mem[(ai+1) % DEPTH] = wd[15:8];
        end else begin
            exp_rd  = {ref_mem[(ai+1) % DEPTH], ref_mem[ai]};
            exp_lat = 4;
            exp_wr  = 0;
        end
        last_rd = exp_rd;
        chk({tag, ".latency"}, n, exp_lat);
        chk({tag, ".err"}, resp_err, exp_err);
        chk({tag, ".rdata"}, resp_rdata, exp_rd);
        chk({tag, ".mem_writes"}, wq_addr.size(), exp_wr);
        if (exp_wr == 2 && wq_addr.size() == 2) begin
            chk({tag, ".wr_addr0"}, wq_addr[0], ai);
            chk({tag, ".wr_data0"}, wq_data[0], wd[7:0]);
            chk({tag, ".wr_addr1"}, wq_addr[1], (ai+1) % DEPTH);
            chk({tag, ".wr_data1"}, wq_data[1], wd[15:8]);
            chk({tag, ".wr_adjacent"}, wq_cyc[1], wq_cyc[0] + 1);
        end
        if (exp_err) chk({tag, ".addr_hold"}, mem_addr, ma0);
        @(negedge clock);
        chk({tag, ".pulse_end"}, resp_valid, 0);
        chk({tag, ".ready_back"}, req_ready, 1);
    endtask

    initial begin
        logic [15:0] rdy_bits;
        logic [15:0] pulse_bits;
        logic [15:0] b2b_rd [2];
        logic [15:0] a;
        int          pulses;
        int          sel;
        int          bad;

        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem['h20] = 8'h00;
        mem['h21] = 8'h00;
        ref_mem['h20] = 8'h00;
        ref_mem['h21] = 8'h00;

        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst.ready", req_ready, 1);
        chk("rst.resp_valid", resp_valid, 0);
        chk("rst.rdata", resp_rdata, 0);
        chk("rst.err", resp_err, 0);
        chk("rst.mem_addr", mem_addr, 0);
        chk("rst.mem_wdata", mem_wdata, 0);
        chk("rst.mem_we", mem_we, 0);
        reset = 1'b0;

        xfer(1'b1, 16'h0010, 16'hBEEF, "wr_beef");
        xfer(1'b0, 16'h0010, 16'h0000, "rd_beef");
        chk("rd_beef.value", resp_rdata, 16'hBEEF);

        xfer(1'b1, 16'h3FFF, 16'h1234, "wr_top");
        chk("wr_top.mem_hi", mem['h3FFF], ref_mem['h3FFF]);
        chk("wr_top.mem_wrap", mem[0], ref_mem[0]);
`ifndef MEM_WORD_BRIDGE_ALIGN_CHECK_EN
        chk("wr_top.lo_const", mem['h3FFF], 8'h34);
        chk("wr_top.hi_const", mem[0], 8'h12);
`endif
        xfer(1'b0, 16'h3FFF, 16'h0000, "rd_top");

        xfer(1'b0, 16'h4000, 16'h0000, "rd_oor");

        // Two reads with req_valid held high throughout.
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 16'h0010;
        rdy_bits   = '0;
        pulse_bits = '0;
        pulses     = 0;
        b2b_rd[0]  = '0;
        b2b_rd[1]  = '0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clock);
            if (c == 6) req_valid = 1'b0;
            rdy_bits[c] = req_ready;
            if (resp_valid === 1'b1) begin
                pulse_bits[c] = 1'b1;
                if (pulses < 2) b2b_rd[pulses] = resp_rdata;
                pulses++;
            end
        end
        last_rd = {ref_mem['h11], ref_mem['h10]};
        chk("b2b.ready_pattern", rdy_bits, 16'h0C20);
        chk("b2b.pulse_pattern", pulse_bits, 16'h0210);
        chk("b2b.pulse_count", pulses, 2);
        chk("b2b.rdata0", b2b_rd[0], last_rd);
        chk("b2b.rdata1", b2b_rd[1], last_rd);

        // Reset lands on the edge that would enter WR1.
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0020;
        req_wdata = 16'hAAAA;
        @(negedge clock);
        req_valid = 1'b0;
        chk("rst_mid.we_wr0", mem_we, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        ref_mem['h20] = 8'hAA;
        last_rd = '0;
        chk("rst_mid.we_drop", mem_we, 0);
        chk("rst_mid.no_resp", resp_valid, 0);
        chk("rst_mid.ready", req_ready, 1);
        pulses = 0;
        repeat (5) begin
            @(negedge clock);
            if (resp_valid === 1'b1) pulses++;
        end
        chk("rst_mid.no_pulse", pulses, 0);
        chk("rst_mid.mem_lo", mem['h20], 8'hAA);
        chk("rst_mid.mem_hi", mem['h21], 8'h00);

        xfer(1'b0, 16'h0011, 16'h0000, "rd_odd");

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 7);
            if (sel == 0)
                a = 16'h3FFF;
            else if (sel == 1)
                a = {2'($urandom_range(1, 3)), 14'($urandom)};
            else if (sel < 5)
                a = 16'($urandom_range(0, 31));
            else
                a = {2'b00, 14'($urandom)};
            xfer(1'($urandom), a, 16'($urandom),
                 $sformatf("rnd%0d", i));
        end

        bad = 0;
        for (int i = 0; i < DEPTH; i++)
            if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_image", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
